fb_rect_fill: RTL and testbench
===============================

# fb_rect_fill

Rectangle-fill engine that writes solid or checkerboard 4-bit colour indices into the 64x32-entry foreground buffer of the VGA pipeline. It sits directly upstream of the video multiplexer's frame-buffer write port (`fwaddr`/`fwdata`/`fwenable`), letting the game controller clear and draw screen regions with a single command. It performs one buffer write per accepted cycle, clips rectangles at the right and bottom edges, and reports completion with a one-cycle pulse.

## Interface
- No parameters; the geometry is fixed at 64 columns x 32 rows with 4-bit entries.
- `clk` in 1: system clock (the 25 MHz pixel-domain clock used by the sprite controller).
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `x0` in 6: left column, 0..63.
- `y0` in 5: top row, 0..31.
- `w` in 7: width in entries, 1..64.
- `h` in 6: height in entries, 1..32.
- `color_a` in 4: primary colour.
- `color_b` in 4: alternate colour, used only in checker mode.
- `checker` in 1: 0 selects a solid fill; 1 selects a checkerboard.
- `abort` in 1: stops an active fill at the next cycle.
- `fw_ready` in 1: the buffer port accepts the write when `fwenable` and `fw_ready` are both high.
- `fwaddr` out 11: `{row[4:0], col[5:0]}`.
- `fwdata` out 4: write data.
- `fwenable` out 1: write request.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a fill, whether completed or aborted.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- States are IDLE, CHECK, WRITE and FINISH.
- **IDLE**
  - When `start` is high, register all command inputs and go to CHECK.
  - Otherwise stay in IDLE.
- **CHECK** (one cycle)
  - If `w==0` or `h==0`: pulse `err` and return to IDLE. No writes occur and `done` is not pulsed.
  - Otherwise compute `xe = min(x0+w-1, 63)` and `ye = min(y0+h-1, 31)`.
    - Both sums use 7-bit arithmetic, so there is no wrap-around: a rectangle never wraps to column 0 or row 0.
  - Load `col=x0`, `row=y0` and go to WRITE.
- **WRITE**
  - `fwenable` is high; `fwaddr={row,col}`.
  - `fwdata` in solid mode is `color_a`.
  - `fwdata` in checker mode is `color_a` when `(row[0]^col[0])==0`, else `color_b`.
  - On an accepted write (`fw_ready=1`), advance in raster order:
    - `col+1` while `col<xe`.
    - Otherwise set `col=x0` and `row+1`.
    - After the write at `(xe,ye)`, go to FINISH.
  - While `fw_ready=0`, `fwaddr`, `fwdata` and `fwenable` hold steady.
  - `abort=1`: go to FINISH without issuing further writes. A write accepted in the same cycle as `abort` counts as performed.
- **FINISH** (one cycle)
  - Pulse `done`, drop `busy`, return to IDLE.
- Commands:
  - `start` is ignored while `busy` is high; it is not queued.
  - A simultaneous `start` and `abort` in IDLE starts the command; `abort` is ignored in IDLE.
- Write count for a valid command is `(xe-x0+1)*(ye-y0+1)`.
- Reset:
  - All state returns to IDLE.
  - `fwaddr=0`, `fwdata=0`, `fwenable=0`, `busy=0`, `done=0`, `err=0`.
  - Asserting reset mid-fill cancels the fill immediately. No `done` pulse is produced; the buffer contents already written remain.

## Timing
- All outputs are registered.
- Start to first write:
  - `start` is sampled at edge N.
  - `busy=1` from edge N.
  - CHECK occupies cycle N..N+1.
  - The first `fwenable` is high after edge N+1.
- Throughput is one write per cycle while `fw_ready` is high.
- End of fill:
  - The last accepted write is at edge M.
  - `done=1` for the single cycle after edge M+1; `busy` falls at edge M+2.
- Rejection:
  - `err=1` for one cycle after the CHECK edge.
  - `busy` is high for exactly the two cycles (CHECK, then the `err` cycle).
- The earliest next `start` is the cycle in which `busy` is low.

## Test plan
- **Solid fill, no stalls.** Reset low, then start with `x0=2, y0=3, w=3, h=2, color_a=5, checker=0`, `fw_ready=1`.
  - Expect 6 consecutive writes to addresses `{3,2},{3,3},{3,4},{4,2},{4,3},{4,4}` (0xC2, 0xC3, 0xC4, 0x102, 0x103, 0x104), all with data 5.
  - Then `done` pulses once and `busy` falls.
- **Clipping.** `x0=62, y0=31, w=4, h=3`.
  - Expect exactly 2 writes, to 0x7FE and 0x7FF.
  - No write lands in column 0/1 or row 0.
- **Checker with back-pressure.** `x0=0, y0=0, w=2, h=2, checker=1, color_a=1, color_b=14`; `fw_ready` low for 3 cycles during the second write.
  - Expect the data sequence 1, 14, 14, 1.
  - The second write's address and data are held stable throughout the stall; 4 writes total.
- **Rejection and busy ignore.**
  - Start with `w=0`: expect `err` for one cycle, no `fwenable`, no `done`.
  - Then a valid 8x1 fill with a second `start` asserted mid-fill: expect the second `start` to be ignored and exactly 8 writes.
- **Abort.** Full-screen fill (`w=64, h=32`), `abort` pulsed after 10 accepted writes.
  - Expect no further `fwenable` and `done` one cycle later.
  - A fresh 1x1 command afterwards writes correctly.
- **Async reset mid-fill.** Drop `rst` asynchronously between clock edges during a fill.
  - Expect all outputs 0 immediately, without waiting for a clock edge, and no `done` pulse.
  - After `rst` is released, a new command behaves normally.

Source files
------------

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for the 64x32 foreground buffer: walks a clipped
// rectangle in raster order and issues one buffer write per accepted cycle.
module fb_rect_fill (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  x0,
    input  logic [4:0]  y0,
    input  logic [6:0]  w,
    input  logic [5:0]  h,
    input  logic [3:0]  color_a,
    input  logic [3:0]  color_b,
    input  logic        checker_mode,
    input  logic        abort,
    input  logic        fw_ready,
    output logic [10:0] fwaddr,
    output logic [3:0]  fwdata,
    output logic        fwenable,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, FINISH} state_t;

    typedef struct packed {
        logic [5:0] x0;
        logic [4:0] y0;
        logic [6:0] w;
        logic [5:0] h;
        logic [3:0] color_a;
        logic [3:0] color_b;
        logic       checker_mode;
    } cmd_t;

    state_t     state, state_n;
    cmd_t       cmd;
    logic [5:0] xe, col, col_n;
    logic [4:0] ye, row, row_n;
    logic [7:0] xsum, ysum;
    logic [5:0] xe_c;
    logic [4:0] ye_c;
    logic [3:0] data_n;
    logic       launch, reject, accept, last;

    // Extents are computed wide enough that nothing wraps, then clamped.
    always_comb begin
        xsum = {2'b00, cmd.x0} + {1'b0, cmd.w} - 8'd1;
        ysum = {3'b000, cmd.y0} + {2'b00, cmd.h} - 8'd1;
        xe_c = (xsum > 8'd63) ? 6'd63 : xsum[5:0];
        ye_c = (ysum > 8'd31) ? 5'd31 : ysum[4:0];
    end

    // busy stays high through the done/err cycle, so start is only taken
    // once that pulse is over.
    assign launch = (state == IDLE) && start && !busy;
    assign reject = (state == CHECK) && ((cmd.w == 7'd0) || (cmd.h == 6'd0));
    assign accept = (state == WRITE) && fw_ready;
    assign last   = (col == xe) && (row == ye);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        case (state)
            IDLE: begin
                if (launch) state_n = CHECK;
            end
            CHECK: begin
                if (reject) begin
                    state_n = IDLE;
                end else begin
                    state_n = WRITE;
                    col_n   = cmd.x0;
                    row_n   = cmd.y0;
                end
            end
            WRITE: begin
                if (accept) begin
                    if (last) begin
                        state_n = FINISH;
                    end else if (col == xe) begin
                        col_n = cmd.x0;
                        row_n = row + 5'd1;
                    end else begin
                        col_n = col + 6'd1;
                    end
                end
                if (abort) state_n = FINISH;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign data_n = (cmd.checker_mode && (row_n[0] ^ col_n[0])) ? cmd.color_b : cmd.color_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd      <= '0;
            xe       <= '0;
            ye       <= '0;
            col      <= '0;
            row      <= '0;
            fwaddr   <= '0;
            fwdata   <= '0;
            fwenable <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            col <= col_n;
            row <= row_n;
            if (launch) begin
                cmd.x0           <= x0;
                cmd.y0           <= y0;
                cmd.w            <= w;
                cmd.h            <= h;
                cmd.color_a      <= color_a;
                cmd.color_b      <= color_b;
                cmd.checker_mode <= checker_mode;
            end
            if (state == CHECK) begin
                xe <= xe_c;
                ye <= ye_c;
            end
            // Write port is registered; during a stall col/row hold, so
            // address and data hold too.
            fwenable <= (state_n == WRITE);
            if (state_n == WRITE) begin
                fwaddr <= {row_n, col_n};
                fwdata <= data_n;
            end
            busy <= (state_n != IDLE) || (state == FINISH) || reject;
            done <= (state == FINISH);
            err  <= reject;
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: a raster model fills the expected-write
// queue, a negedge monitor pops and compares every accepted write.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  x0 = '0;
    logic [4:0]  y0 = '0;
    logic [6:0]  w = '0;
    logic [5:0]  h = '0;
    logic [3:0]  color_a = '0;
    logic [3:0]  color_b = '0;
    logic        checker_mode = 1'b0;
    logic        abort = 1'b0;
    logic        fw_ready = 1'b1;
    logic [10:0] fwaddr;
    logic [3:0]  fwdata;
    logic        fwenable;
    logic        busy;
    logic        done;
    logic        err;

    fb_rect_fill dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color_a(color_a), .color_b(color_b), .checker_mode(checker_mode),
        .abort(abort), .fw_ready(fw_ready), .fwaddr(fwaddr), .fwdata(fwdata),
        .fwenable(fwenable), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [10:0] addr; logic [3:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int compared = 0, mismatched = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, stall_cnt = 0, last_wr_cyc = -100;
    int exp_n = 0, base_w = 0, base_d = 0, base_e = 0, base_s = 0;
    bit rdy_mode = 1'b0;
    logic rdy_force = 1'b1;
    logic hold_pend = 1'b0, done_prev = 1'b0, err_prev = 1'b0;
    logic [10:0] hold_addr = '0;
    logic [3:0]  hold_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: every (row,col) of the clipped rectangle in raster order.
    function automatic int push_rect(input int xs, input int ys, input int wd, input int ht,
                                     input int ca, input int cb, input bit chkr, input int limit);
        int n, xl, yl;
        wr_t e;
        n = 0;
        if (wd == 0 || ht == 0) return 0;
        xl = (xs + wd - 1 > 63) ? 63 : xs + wd - 1;
        yl = (ys + ht - 1 > 31) ? 31 : ys + ht - 1;
        for (int r = ys; r <= yl; r++)
            for (int c = xs; c <= xl; c++)
                if (n < limit) begin
                    e.addr = 11'(r * 64 + c);
                    e.data = (chkr && ((r + c) % 2 == 1)) ? 4'(cb) : 4'(ca);
                    exp_q.push_back(e);
                    n++;
                end
        return n;
    endfunction

    always @(posedge clk) begin
        #2;
        fw_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            hold_pend = 1'b0;
            done_prev = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("stall_hold_en", fwenable, 1);
                chk("stall_hold_addr", fwaddr, hold_addr);
                chk("stall_hold_data", fwdata, hold_data);
            end
            hold_pend = fwenable && !fw_ready;
            if (hold_pend) begin
                hold_addr = fwaddr;
                hold_data = fwdata;
                stall_cnt++;
            end
            if (fwenable && fw_ready) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got addr 0x%0h data %0d, expected no write", fwaddr, fwdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", fwaddr, mon_e.addr);
                    chk("wr_data", fwdata, mon_e.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc - last_wr_cyc, 2);
                chk("busy_during_done", busy, 1);
                chk("done_single", done_prev, 0);
            end
            if (done_prev && !done) chk("busy_after_done", busy, 0);
            if (err) begin
                err_cnt++;
                chk("err_single", err_prev, 0);
                chk("err_no_write", fwenable, 0);
            end
            done_prev = done;
            err_prev  = err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int xs, input int ys, input int wd, input int ht,
                         input int ca, input int cb, input bit chkr, input int limit);
        exp_n  = push_rect(xs, ys, wd, ht, ca, cb, chkr, limit);
        base_w = wr_cnt;
        base_d = done_cnt;
        base_e = err_cnt;
        base_s = stall_cnt;
        x0 = 6'(xs); y0 = 5'(ys); w = 7'(wd); h = 6'(ht);
        color_a = 4'(ca); color_b = 4'(cb); checker_mode = chkr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_cmd(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < max_cyc);
        chk({name, "_busy_timeout"}, busy, 0);
        repeat (4) tick();
        chk({name, "_writes"}, wr_cnt - base_w, exp_n);
        chk({name, "_done"}, done_cnt - base_d, (exp_n > 0) ? 1 : 0);
        chk({name, "_err"}, err_cnt - base_e, (exp_n > 0) ? 0 : 1);
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_fwaddr", fwaddr, 0);
        chk("rst_fwdata", fwdata, 0);
        chk("rst_fwenable", fwenable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        repeat (2) tick();

        // solid fill with start-to-first-write latency
        issue(2, 3, 3, 2, 5, 0, 1'b0, 1 << 30);
        chk("solid_check_busy", busy, 1);
        chk("solid_check_noen", fwenable, 0);
        tick();
        chk("solid_first_en", fwenable, 1);
        chk("solid_first_addr", fwaddr, 11'h0C2);
        chk("solid_first_data", fwdata, 5);
        finish_cmd("solid", 50);

        // clipping at right/bottom edges
        issue(62, 31, 4, 3, 9, 0, 1'b0, 1 << 30);
        finish_cmd("clip", 50);

        // checker with a 3-cycle stall on the second write
        issue(0, 0, 2, 2, 1, 14, 1'b1, 1 << 30);
        tick();
        tick();
        rdy_force = 1'b0;
        repeat (3) tick();
        rdy_force = 1'b1;
        finish_cmd("checker", 50);
        chk("checker_stalls", stall_cnt - base_s, 3);

        // rejection
        issue(5, 5, 0, 3, 3, 0, 1'b0, 1 << 30);
        chk("rej_check_busy", busy, 1);
        chk("rej_check_err", err, 0);
        tick();
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 1);
        finish_cmd("reject", 20);

        // start while busy is ignored
        issue(10, 5, 8, 1, 6, 0, 1'b0, 1 << 30);
        repeat (3) tick();
        x0 = 6'd0; y0 = 5'd0; w = 7'd4; h = 6'd4; color_a = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_cmd("ignore", 50);

        // abort a full-screen fill after 10 accepted writes
        issue(0, 0, 64, 32, 7, 9, 1'b1, 11);
        n = 0;
        while (wr_cnt - base_w < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reach10", wr_cnt - base_w, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        finish_cmd("abort", 50);
        issue(20, 10, 1, 1, 11, 0, 1'b0, 1 << 30);
        finish_cmd("after_abort", 20);

        // async reset mid-fill
        rdy_mode = 1'b1;
        issue(0, 0, 64, 32, 4, 12, 1'b1, 1 << 30);
        repeat (20) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_fwaddr", fwaddr, 0);
        chk("arst_fwdata", fwdata, 0);
        chk("arst_fwenable", fwenable, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("arst_no_done", done_cnt - base_d, 0);
        chk("arst_idle", busy, 0);
        issue(30, 20, 5, 3, 13, 2, 1'b1, 1 << 30);
        finish_cmd("after_rst", 100);

        // randomized commands under random back-pressure
        for (int i = 0; i < 25; i++) begin
            int xs, ys, wd, ht, r;
            xs = $urandom_range(0, 63);
            ys = $urandom_range(0, 31);
            wd = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 64) : $urandom_range(1, 12);
            ht = $urandom_range(1, 6);
            r  = $urandom_range(0, 9);
            if (r == 0) wd = 0;
            if (r == 1) ht = 0;
            issue(xs, ys, wd, ht, $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1 << 30);
            finish_cmd("rand", 4 * exp_n + 50);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
